// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared cacheline-adaptor port between the instruction and data caches.
// One line transaction is outstanding at a time; the completion is returned as a one-cycle resp pulse.
module cache_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int OFFSET_W    = 5,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] instr_cache_address,
    input  logic              instr_cache_read,
    input  logic              instr_cache_write,
    input  logic [LINE_W-1:0] instr_cache_to_pmem,
    output logic [LINE_W-1:0] instr_pmem_to_cache,
    output logic              instr_cache_resp,

    input  logic [ADDR_W-1:0] data_cache_address,
    input  logic              data_cache_read,
    input  logic              data_cache_write,
    input  logic [LINE_W-1:0] data_cache_to_pmem,
    output logic [LINE_W-1:0] data_pmem_to_cache,
    output logic              data_cache_resp,

    output logic [ADDR_W-1:0] cache_address,
    output logic              cache_read,
    output logic              cache_write,
    output logic [LINE_W-1:0] cache_to_pmem,
    input  logic [LINE_W-1:0] pmem_to_cache,
    input  logic              cache_resp
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              last_data_q, last_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] instr_rdata_q, instr_rdata_d;
    logic [LINE_W-1:0] data_rdata_q, data_rdata_d;
    logic              instr_resp_q, instr_resp_d;
    logic              data_resp_q, data_resp_d;

    logic instr_pending;
    logic data_pending;
    logic grant_data;

    assign instr_pending = instr_cache_read | instr_cache_write;
    assign data_pending  = data_cache_read | data_cache_write;

    // On contention, round robin hands the port to whoever did not win last time.
    always_comb begin
        grant_data = data_pending;
        if (instr_pending && data_pending) begin
            grant_data = (ROUND_ROBIN != 0) ? ~last_data_q : 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_data_d   = last_data_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_d        = read_q;
        write_d       = write_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        instr_resp_d  = 1'b0;
        data_resp_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read from the same requester.
                if (instr_pending || data_pending) begin
                    if (grant_data) begin
                        state_d     = BUSY_D;
                        last_data_d = 1'b1;
                        addr_d      = {data_cache_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        wdata_d     = data_cache_to_pmem;
                        write_d     = data_cache_write;
                        read_d      = ~data_cache_write;
                    end else begin
                        state_d     = BUSY_I;
                        last_data_d = 1'b0;
                        addr_d      = {instr_cache_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        wdata_d     = instr_cache_to_pmem;
                        write_d     = instr_cache_write;
                        read_d      = ~instr_cache_write;
                    end
                end
            end
            BUSY_I: begin
                if (cache_resp) begin
                    if (read_q) begin
                        instr_rdata_d = pmem_to_cache;
                    end
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    instr_resp_d = 1'b1;
                    state_d      = DONE_I;
                end
            end
            BUSY_D: begin
                if (cache_resp) begin
                    if (read_q) begin
                        data_rdata_d = pmem_to_cache;
                    end
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    data_resp_d = 1'b1;
                    state_d     = DONE_D;
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_data_q   <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            instr_resp_q  <= 1'b0;
            data_resp_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_data_q   <= last_data_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_q        <= read_d;
            write_q       <= write_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            instr_resp_q  <= instr_resp_d;
            data_resp_q   <= data_resp_d;
        end
    end

    assign cache_address       = addr_q;
    assign cache_to_pmem       = wdata_q;
    assign cache_read          = read_q;
    assign cache_write         = write_q;
    assign instr_pmem_to_cache = instr_rdata_q;
    assign data_pmem_to_cache  = data_rdata_q;
    assign instr_cache_resp    = instr_resp_q;
    assign data_cache_resp     = data_resp_q;

endmodule
